// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: pattern modes, writer FSM encoding and the
// bank-interleaved address map also used by the video reader.
package fb_pkg;

  localparam logic [1:0] MODE_XRAMP = 2'd0;
  localparam logic [1:0] MODE_YRAMP = 2'd1;
  localparam logic [1:0] MODE_SOLID = 2'd2;
  localparam logic [1:0] MODE_CHECK = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_FINISH = 2'd2
  } fb_state_e;

  typedef struct packed {
    logic [1:0]  bank;
    logic [29:0] addr;
  } fb_loc_t;

  // Linear word address -> {bank, row/col}. Bits [9:8] pick the bank so that
  // consecutive 256-word runs rotate through all four banks.
  function automatic fb_loc_t fb_swizzle(input logic [31:0] lin, input int unsigned addr_w);
    fb_loc_t     r;
    logic [31:0] m;
    m      = lin & ((32'h1 << addr_w) - 32'h1);
    r.bank = m[9:8];
    r.addr = 30'(((m >> 10) << 8) | {24'h0, m[7:0]});
    return r;
  endfunction

endpackage

// File: rtl/fb_pattern_writer_if.sv
// Word write port between the pattern writer and the SDRAM write arbiter.
interface fb_pattern_writer_if #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 16
);
  logic              wr_valid;
  logic              wr_ready;
  logic [1:0]        wr_bank;
  logic [ADDR_W-3:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_valid, wr_bank, wr_addr, wr_data, input wr_ready);
  modport slave  (input wr_valid, wr_bank, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/fb_xy_counter.sv
// Raster x/y counter. Exposes the position that follows the current one so the
// owner can register per-pixel outputs one step ahead.
module fb_xy_counter #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int XW       = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
  parameter int YW       = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [XW-1:0] x_next,
  output logic [YW-1:0] y_next,
  output logic          last
);
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          x_end, y_end;

  assign x_end  = (x == XW'(H_ACTIVE - 1));
  assign y_end  = (y == YW'(V_ACTIVE - 1));
  assign last   = x_end && y_end;
  assign x_next = x_end ? '0 : x + XW'(1);
  assign y_next = x_end ? (y_end ? '0 : y + YW'(1)) : y;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      x <= x_next;
      y <= y_next;
    end
  end

endmodule

// File: rtl/fb_pattern_writer.sv
// Streams one frame of a test pattern into SDRAM through the word write port,
// one registered word per accepted handshake.
module fb_pattern_writer
  import fb_pkg::*;
#(
  parameter int H_ACTIVE    = 1280,
  parameter int V_ACTIVE    = 720,
  parameter int LINE_STRIDE = 4096,
  parameter int ADDR_W      = 22,
  parameter int DATA_W      = 16,
  parameter int CHK_LOG2    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] color,
  output logic              busy,
  output logic              done,
  fb_pattern_writer_if.master wr
);
  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int SW = $clog2(LINE_STRIDE);

  fb_state_e         state_q, state_d;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] color_q;
  logic [XW-1:0]     nx, px;
  logic [YW-1:0]     ny, py;
  logic              last, accept, load_first, step;
  logic [1:0]        pmode;
  logic [DATA_W-1:0] pcolor, pdata;
  logic              chk_sel;
  logic [31:0]       lin;
  fb_loc_t           loc;
  logic              unused_loc;

  assign accept     = wr.wr_valid && wr.wr_ready;
  assign load_first = (state_q == ST_IDLE) && start;
  assign step       = accept && !last;

  fb_xy_counter #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .XW(XW), .YW(YW)) u_xy (
    .clk    (clk),
    .reset  (reset),
    .clr    (load_first),
    .en     (accept),
    .x_next (nx),
    .y_next (ny),
    .last   (last)
  );

  // Outputs are registered one word ahead: the first word comes from the live
  // mode/colour at start, later words from the latched copies.
  assign px     = load_first ? '0 : nx;
  assign py     = load_first ? '0 : ny;
  assign pmode  = load_first ? mode : mode_q;
  assign pcolor = load_first ? color : color_q;

  assign lin        = 32'({py, SW'(px)});
  assign loc        = fb_swizzle(lin, ADDR_W);
  assign unused_loc = ^loc.addr[29:ADDR_W-2];

  always_comb begin
    chk_sel = |(((32'(px) >> CHK_LOG2) ^ (32'(py) >> CHK_LOG2)) & 32'd1);
    pdata   = pcolor;
    case (pmode)
      MODE_XRAMP: pdata = DATA_W'(px);
      MODE_YRAMP: pdata = DATA_W'(py);
      MODE_SOLID: pdata = pcolor;
      MODE_CHECK: pdata = chk_sel ? pcolor : ~pcolor;
      default:    pdata = pcolor;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_WRITE;
      ST_WRITE:  if (accept && last) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q     <= MODE_XRAMP;
      color_q    <= '0;
      wr.wr_bank <= '0;
      wr.wr_addr <= '0;
      wr.wr_data <= '0;
    end else begin
      if (load_first) begin
        mode_q  <= mode;
        color_q <= color;
      end
      if (load_first || step) begin
        wr.wr_bank <= loc.bank;
        wr.wr_addr <= loc.addr[ADDR_W-3:0];
        wr.wr_data <= pdata;
      end
    end
  end

  assign wr.wr_valid = (state_q == ST_WRITE);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_FINISH);

endmodule

// File: doc/fb_pattern_writer.md
# fb_pattern_writer

Hardware framebuffer initialiser. It streams a parametrised test pattern into SDRAM through the SDRAM controller's word write port, using the same bank-interleaved address mapping the video reader uses. It replaces the simulation-only memory preload, so frames can be generated on silicon. It supports variable resolution, line stride, pixel width and several pattern modes. It sits between the top-level control logic and the SDRAM controller write arbiter port.

## Interface

Parameters:
- H_ACTIVE, 1280: pixels per line written; must be ≤ LINE_STRIDE.
- V_ACTIVE, 720: lines per frame.
- LINE_STRIDE, 4096: words per line in memory; power of two.
- ADDR_W, 22: linear word-address width (4M × 16 device).
- DATA_W, 16: pixel/word width.
- CHK_LOG2, 3: checkerboard cell size is 2^CHK_LOG2 pixels.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- start, in, 1: begin a frame; sampled only in IDLE.
- mode, in, 2: pattern select. 0 = x ramp, 1 = y ramp, 2 = solid, 3 = checkerboard.
- color, in, DATA_W: solid and checkerboard colour.
- busy, out, 1: frame in progress.
- done, out, 1: one-cycle pulse after the last word is accepted.
- wr_valid, out, 1: write request.
- wr_ready, in, 1: controller accepts the word this cycle.
- wr_bank, out, 2: SDRAM bank.
- wr_addr, out, ADDR_W-2: row/column word address within the bank.
- wr_data, out, DATA_W: pixel word.

## Operation

- States: IDLE, WRITE, FINISH.
- IDLE:
  - On start=1, clear x and y to 0, latch mode and color, and go to WRITE.
  - start while busy is ignored.
- WRITE:
  - wr_valid=1.
  - On wr_valid&&wr_ready, advance: x++. If x==H_ACTIVE-1, then x=0 and y++.
  - Accepting (H_ACTIVE-1, V_ACTIVE-1) moves to FINISH.
- FINISH: done=1 for one cycle, then go to IDLE.
- Address generation:
  - lin = y*LINE_STRIDE + x, formed by concatenation because LINE_STRIDE is a power of two; truncated to ADDR_W.
  - wr_bank = lin[9:8].
  - wr_addr = {lin[ADDR_W-1:10], lin[7:0]}.
- Data generation (all values zero-extended or truncated to DATA_W):
  - Mode 0: x.
  - Mode 1: y.
  - Mode 2: latched color.
  - Mode 3: ((x>>CHK_LOG2) ^ (y>>CHK_LOG2)) bit 0 selects color when 1 and ~color when 0.
- busy=1 in WRITE and FINISH.
- Reset values: state IDLE, x=y=0, busy=0, done=0, wr_valid=0, wr_bank=0, wr_addr=0, wr_data=0.

## Timing

- start high at edge k puts wr_valid high after edge k; the first word is (0,0).
- With wr_ready held high, throughput is one word per cycle.
- The last acceptance at edge m gives done=1 and busy=1 for the cycle after edge m, and busy=0 after edge m+1.
- Handshake: wr_bank, wr_addr and wr_data are registered. They stay stable while wr_valid&&!wr_ready and change only after an acceptance edge.
- wr_valid never drops mid-frame except on reset.
- Reset during WRITE: outputs go to their reset values immediately (asynchronous). No partial-frame done is produced. The next start begins again at (0,0).
- mode and color changes mid-frame have no effect until the next start.
- With mode=3 and CHK_LOG2 ≥ the counter width, the pattern degenerates to ~color everywhere. This is legal.

## Structure

- Shared package `fb_pkg`:
  - Pattern mode constants (MODE_XRAMP, MODE_YRAMP, MODE_SOLID, MODE_CHECK).
  - State encoding.
  - Bank-swizzle function (linear address → bank and row/column), shared with the video reader so both sides map addresses identically.
- One natural sub-module, `fb_xy_counter`: raster x/y counter with enable, wrap, last flag, and widths $clog2(H_ACTIVE) and $clog2(V_ACTIVE).
- Pattern and address logic stay in the top module.

## Test plan

- Default params, mode 0, wr_ready=1:
  - Exactly 921600 accepts; done arrives 921601 cycles after start.
  - (x=5, y=3) gives bank 0, addr 3077, data 5.
  - (x=300, y=0) gives bank 1, addr 44, data 300.
- Backpressure:
  - Random wr_ready at 30% duty.
  - Outputs stay constant during stalls.
  - Scoreboard sees every (x,y) exactly once, in raster order.
- Mode 3, color=0xF800, CHK_LOG2=3: (0,0) gives 0x07FF, (8,0) gives 0xF800, (8,8) gives 0x07FF.
- H_ACTIVE=4, V_ACTIVE=2, mode 2, color=0x1234:
  - 8 accepts, all data 0x1234.
  - Line 0 at bank 0, addr 0–3; line 1 at bank 0, addr 1024–1027.
  - done pulses once.
- start pulsed mid-frame is ignored (count unchanged). Reset asserted at the 1000th accept clears wr_valid and busy immediately. A new start then restarts at addr 0 with data 0.
